// File: rtl/sram_pattern_fetch.sv
// Multi-layer SRAM pattern fetcher: reads WORDS words per enabled layer and ORs layers into one pattern.
// States: IDLE = parked, addr 0 | READY = await start | FETCH = reading words | DONE = pattern published.
module sram_pattern_fetch #(
  parameter int DW           = 16,
  parameter int AW           = 20,
  parameter int WORDS        = 4,
  parameter int LAYERS       = 2,
  parameter int BAR_W        = 4,
  parameter int LAYER_STRIDE = 64
) (
  input  logic                i_bclk,
  input  logic                i_rst,
  input  logic                i_mode,
  input  logic                i_start,
  input  logic [BAR_W-1:0]    i_bar,
  input  logic [LAYERS-1:0]   i_layer_mask,
  input  logic [DW-1:0]       i_SRAM_DQ,
  output logic [AW-1:0]       o_addr,
  output logic [WORDS*DW-1:0] o_data,
  output logic                o_valid,
  output logic                o_busy
);

  localparam int LW  = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, READY, FETCH, DONE} state_t;

  state_t              state;
  logic [BAR_W-1:0]    bar_q;
  logic [LAYERS-1:0]   pending;
  logic [WCW-1:0]      word;
  logic [WORDS*DW-1:0] acc;
  logic [WORDS*DW-1:0] acc_next;

  function automatic logic [LW-1:0] lowest_set(input logic [LAYERS-1:0] m);
    lowest_set = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = LW'(i);
    end
  endfunction

  function automatic logic [AW-1:0] layer_addr(input logic [BAR_W-1:0] bar,
                                               input logic [LW-1:0] k);
    layer_addr = (AW'(bar) + AW'(1)) * AW'(WORDS) + AW'(k) * AW'(LAYER_STRIDE);
  endfunction

  always_comb begin
    acc_next = acc;
    acc_next[int'(word)*DW +: DW] = acc[int'(word)*DW +: DW] | i_SRAM_DQ;
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state   <= IDLE;
      bar_q   <= '0;
      pending <= '0;
      word    <= '0;
      acc     <= '0;
      o_addr  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_addr <= '0;
          if (i_mode) state <= READY;
        end

        READY: begin
          if (!i_mode) begin
            state  <= IDLE;
            o_addr <= '0;
          end else if (i_start) begin
            bar_q <= i_bar;
            acc   <= '0;
            word  <= '0;
            o_busy <= 1'b1;
            if (i_layer_mask != '0) begin
              state   <= FETCH;
              o_addr  <= layer_addr(i_bar, lowest_set(i_layer_mask));
              pending <= i_layer_mask & (i_layer_mask - LAYERS'(1));
            end else begin
              // Empty mask publishes an all-zero pattern straight away.
              state   <= DONE;
              pending <= '0;
              o_data  <= '0;
              o_valid <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (!i_mode) begin
            state  <= IDLE;
            o_addr <= '0;
            o_busy <= 1'b0;
          end else begin
            acc <= acc_next;
            if (word == LAST_WORD) begin
              word <= '0;
              if (pending != '0) begin
                o_addr  <= layer_addr(bar_q, lowest_set(pending));
                pending <= pending & (pending - LAYERS'(1));
              end else begin
                state   <= DONE;
                o_addr  <= o_addr + AW'(1);
                o_data  <= acc_next;
                o_valid <= 1'b1;
              end
            end else begin
              word   <= word + WCW'(1);
              o_addr <= o_addr + AW'(1);
            end
          end
        end

        DONE: begin
          o_busy <= 1'b0;
          if (i_mode) begin
            state <= READY;
          end else begin
            state  <= IDLE;
            o_addr <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          o_addr <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pattern_fetch.sv
// Bench for sram_pattern_fetch: default instance plus a 6-bit-address instance for wrap checks,
// both compared against a list-based reference of addresses and OR-ed pattern.
module tb_sram_pattern_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_a, mode_b;
  logic        start;
  logic [3:0]  bar;
  logic [1:0]  mask;
  logic [15:0] dq_a, dq_b;
  logic [19:0] addr_a;
  logic [5:0]  addr_b;
  logic [63:0] data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int          kind;
  logic [15:0] seed;
  int          compared = 0;
  int          mismatched = 0;
  logic [63:0] prev_a = '0;
  logic [63:0] prev_b = '0;

  always #5 clk = ~clk;

  sram_pattern_fetch dut (
    .i_bclk(clk), .i_rst(rst), .i_mode(mode_a), .i_start(start), .i_bar(bar),
    .i_layer_mask(mask), .i_SRAM_DQ(dq_a), .o_addr(addr_a), .o_data(data_a),
    .o_valid(valid_a), .o_busy(busy_a)
  );

  sram_pattern_fetch #(.AW(6)) dut_w (
    .i_bclk(clk), .i_rst(rst), .i_mode(mode_b), .i_start(start), .i_bar(bar),
    .i_layer_mask(mask), .i_SRAM_DQ(dq_b), .o_addr(addr_b), .o_data(data_b),
    .o_valid(valid_b), .o_busy(busy_b)
  );

  // Asynchronous SRAM model: data is a pure function of the address.
  function automatic logic [15:0] sram_fn(input int a, input int k, input logic [15:0] s);
    logic [31:0] h;
    h = 32'(a) * 32'd40503;
    case (k)
      0:       sram_fn = 16'(a) ^ s;
      1:       sram_fn = (a >= 64) ? 16'hF000 : 16'h000F;
      default: sram_fn = h[15:0] ^ s;
    endcase
  endfunction

  always_comb dq_a = sram_fn(int'(addr_a), kind, seed);
  always_comb dq_b = sram_fn(int'(addr_b), kind, seed);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sel_addr(input bit inst);
    sel_addr = inst ? 64'(addr_b) : 64'(addr_a);
  endfunction
  function automatic logic [63:0] sel_data(input bit inst);
    sel_data = inst ? data_b : data_a;
  endfunction
  function automatic logic sel_valid(input bit inst);
    sel_valid = inst ? valid_b : valid_a;
  endfunction
  function automatic logic sel_busy(input bit inst);
    sel_busy = inst ? busy_b : busy_a;
  endfunction

  // Entered at a negedge with the selected instance in READY; returns at a negedge.
  task automatic run_fetch(input bit inst, input int b, input int m, input bit poke,
                           input int abort_at, input int rst_at);
    int          exp_addr[$];
    logic [63:0] pat;
    logic [63:0] prev;
    int          modulus;
    int          a;
    modulus = inst ? 64 : (1 << 20);
    pat = '0;
    for (int k = 0; k < 2; k++) begin
      if (m[k]) begin
        for (int w = 0; w < 4; w++) begin
          a = ((b + 1) * 4 + k * 64 + w) % modulus;
          exp_addr.push_back(a);
          pat[w*16 +: 16] = pat[w*16 +: 16] | sram_fn(a, kind, seed);
        end
      end
    end
    prev = inst ? prev_b : prev_a;

    bar = 4'(b); mask = 2'(m); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= exp_addr.size(); c++) begin
      check("fetch_addr", sel_addr(inst), 64'(exp_addr[c-1]));
      check("fetch_busy", 64'(sel_busy(inst)), 64'd1);
      check("fetch_valid", 64'(sel_valid(inst)), 64'd0);
      check("fetch_data_hold", sel_data(inst), prev);
      start = (poke && c == 2) ? 1'b1 : 1'b0;
      if (c == abort_at) begin
        if (inst) mode_b = 1'b0; else mode_a = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          check("abort_addr", sel_addr(inst), 64'd0);
          check("abort_busy", 64'(sel_busy(inst)), 64'd0);
          check("abort_valid", 64'(sel_valid(inst)), 64'd0);
          check("abort_data", sel_data(inst), prev);
          @(negedge clk);
        end
        return;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_addr", sel_addr(inst), 64'd0);
        check("midrst_data", sel_data(inst), 64'd0);
        check("midrst_valid", 64'(sel_valid(inst)), 64'd0);
        check("midrst_busy", 64'(sel_busy(inst)), 64'd0);
        prev_a = '0; prev_b = '0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_valid", 64'(sel_valid(inst)), 64'd1);
    check("done_busy", 64'(sel_busy(inst)), 64'd1);
    check("done_data", sel_data(inst), pat);
    @(negedge clk);
    check("after_valid", 64'(sel_valid(inst)), 64'd0);
    check("after_busy", 64'(sel_busy(inst)), 64'd0);
    check("after_data", sel_data(inst), pat);
    if (inst) prev_b = pat; else prev_a = pat;
  endtask

  initial begin
    rst = 1'b1; mode_a = 1'b0; mode_b = 1'b0; start = 1'b0;
    bar = '0; mask = '0; kind = 0; seed = 16'hA5A5;

    // Reset held two cycles, then released with mode low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_data", data_a, 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_addr", 64'(addr_a), 64'd0);
      check("idle_busy", 64'(busy_a), 64'd0);
    end
    mode_a = 1'b1;
    @(negedge clk);

    kind = 0; seed = 16'hA5A5;
    run_fetch(0, 2, 1, 1'b0, 0, 0);         // single layer
    kind = 1;
    run_fetch(0, 2, 3, 1'b0, 0, 0);         // two-layer overlay, 16'hF00F
    kind = 0; seed = 16'($urandom);
    run_fetch(0, 0, 2, 1'b0, 0, 0);         // skip layer 0
    run_fetch(0, 5, 0, 1'b0, 0, 0);         // empty mask
    kind = 2; seed = 16'($urandom);
    run_fetch(0, 7, 3, 1'b0, 0, 0);
    run_fetch(0, $urandom_range(0, 15), 3, 1'b0, 3, 0);   // abort in cycle 3
    mode_a = 1'b1;
    @(negedge clk);
    run_fetch(0, 9, 3, 1'b0, 0, 0);
    run_fetch(0, 3, 3, 1'b0, 0, 6);         // reset mid-fetch
    @(negedge clk);

    for (int it = 0; it < 24; it++) begin
      kind = 2; seed = 16'($urandom);
      run_fetch(0, $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        mode_a = 1'b0;
        @(negedge clk);
        check("gap_addr", 64'(addr_a), 64'd0);
        check("gap_busy", 64'(busy_a), 64'd0);
        mode_a = 1'b1;
        @(negedge clk);
      end
    end

    // Narrow-address instance: (15+1)*4 = 64 wraps to 0; a mid-fetch start is ignored.
    mode_a = 1'b0;
    @(negedge clk);
    mode_b = 1'b1;
    @(negedge clk);
    kind = 0; seed = 16'h1234;
    run_fetch(1, 15, 1, 1'b1, 0, 0);
    repeat (4) begin
      check("ignore_busy", 64'(busy_b), 64'd0);
      check("ignore_valid", 64'(valid_b), 64'd0);
      @(negedge clk);
    end
    kind = 2; seed = 16'($urandom);
    run_fetch(1, 15, 3, 1'b0, 0, 0);
    run_fetch(1, $urandom_range(0, 15), 2, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
